cht_shift_sequencer: RTL and testbench
======================================

Name: cht_shift_sequencer

Overview:
Multi-cycle controller for the one-position shift/select datapath used by the cht shifter family. It accepts a command word with data, direction, shift amount and fill bit, and sequences one single-position shift per clock. It returns the result over a valid/ready handshake. It also exports the per-cycle select strobes (hold, direction), so an external cht-style mux array can be driven in lockstep.

Parameters:
WIDTH, 16, data width in bits (>= 2)
CNT_W, 5, width of shift-amount field; amounts 0 .. 2**CNT_W-1

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_data  input  WIDTH  operand
cmd_dir  input  1  0 = shift toward MSB (left), 1 = toward LSB (right)
cmd_amt  input  CNT_W  number of single-position shifts
cmd_fill  input  1  bit shifted into the vacated position
abort  input  1  cancel an in-flight operation
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  shifted result
busy  output  1  high in SHIFT or DONE
sel_hold  output  1  datapath hold strobe, equivalent of cht "l"; high when no shift this cycle
sel_dir  output  1  datapath direction strobe, equivalent of cht "j"; latched cmd_dir

Behaviour:
- Reset (rst_n low at a clock edge), from any state, mid-operation included:
  - state goes to IDLE.
  - res_data=0, res_valid=0, busy=0, sel_hold=1, sel_dir=0, internal count=0.
  - Any pending result is discarded.
- Reset has priority over abort, which has priority over all other events.
- States: IDLE, SHIFT, DONE. Two-bit encoding is free. Unused encodings go to IDLE on the next edge.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at edge E0: load data register=cmd_data, cnt=cmd_amt, and latch dir and fill.
  - If cmd_amt==0, next state is DONE. Otherwise next state is SHIFT.
- SHIFT, each edge:
  - Data register shifts one position per dir. The vacated bit takes fill: LSB when dir=0, MSB when dir=1.
  - cnt decrements by 1. When cnt==1 before the edge, next state is DONE.
- Latency: res_valid is high in the cycle following edge E0+N, where N=cmd_amt. An N=0 command is valid the cycle after accept.
- Amounts >= WIDTH are legal. The operation still takes N cycles, and the result is all fill bits.
- DONE:
  - res_valid=1 and res_data is stable.
  - Holds indefinitely while res_ready=0.
  - On res_ready at an edge, next state is IDLE.
  - res_data holds its last value afterwards; res_valid drops.
- No same-cycle result-to-command overlap: a new command is accepted no earlier than the cycle after the result handshake.
- abort:
  - In SHIFT or DONE, the next state is IDLE and res_valid=0. No result is delivered; an aborted DONE result is lost.
  - In IDLE, abort is ignored, and a simultaneous cmd_valid is not accepted.
- sel_hold=0 only in SHIFT. sel_dir is the latched dir in SHIFT and DONE, and holds its last value in IDLE.
- cmd_* inputs are sampled only on the accept edge. Later changes have no effect.
- busy equals (state != IDLE).

Optional Feature:
Macro: CHT_SEQ_ROTATE_EN.
- Defined:
  - The cmd_fill port still exists but is ignored.
  - The vacated bit takes the bit shifted out, so the operation is a rotate.
  - The result equals rotation by N mod WIDTH, still taking N cycles.
- Undefined: fill behaviour as specified above.

Test Plan:
- WIDTH=16, cmd_data=16'h8001, dir=0, amt=3, fill=0 -> res_valid after 3 edges post-accept; res_data=16'h0008 (rotate build: 16'h000C).
- dir=1, amt=0, data=16'hA5A5, res_ready held low 5 cycles -> res_valid the cycle after accept; data 16'hA5A5 stable through all 5 cycles; cmd_ready=0 throughout; IDLE after handshake.
- dir=1, amt=20, fill=1, data=16'h1234 -> 20 shift cycles with sel_hold=0; res_data=16'hFFFF (rotate build: rotate right by 4 = 16'h4123).
- amt=10, abort asserted after 4 shift cycles -> IDLE next cycle, res_valid never asserts, cmd_ready=1; a following amt=1 command completes normally.
- rst_n low for one edge mid-SHIFT (amt=8, cycle 5), with cmd_valid and abort also high -> all outputs at reset values next cycle; no command accepted that edge.

Source files
------------

// File: rtl/cht_shift_sequencer.sv
// Multi-cycle one-position shift sequencer with valid/ready command and result handshakes.
// Define CHT_SEQ_ROTATE_EN to rotate (the vacated bit takes the bit shifted out) instead of filling.
module cht_shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic             cmd_fill,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             sel_hold,
  output logic             sel_dir
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             fill_q;
  logic             in_left;
  logic             in_right;

  // Bit entering the vacated position: LSB side on a left shift, MSB side on a right shift.
  always_comb begin
`ifdef CHT_SEQ_ROTATE_EN
    in_left  = data_q[WIDTH-1];
    in_right = data_q[0];
`else
    in_left  = fill_q;
    in_right = fill_q;
`endif
    data_d = dir_q ? {in_right, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], in_left};
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees
  // pre-edge values of the others (cnt_q == 1 test and data shift in the same edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else if (abort) begin
      // In IDLE this also blocks a simultaneous command.
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            data_q  <= cmd_data;
            cnt_q   <= cmd_amt;
            dir_q   <= cmd_dir;
            fill_q  <= cmd_fill;
            state_q <= (cmd_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state, so they change only on clock edges.
  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sel_hold  = (state_q != SHIFT);
  assign sel_dir   = dir_q;
  assign res_data  = data_q;

endmodule

// File: tb/tb_cht_shift_sequencer.sv
// Self-checking bench for cht_shift_sequencer: directed cases plus randomized commands
// compared against an arithmetic shift/rotate model.
module tb_cht_shift_sequencer;
  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data;
  logic          cmd_dir;
  logic [CW-1:0] cmd_amt;
  logic          cmd_fill;
  logic          abort;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          busy;
  logic          sel_hold;
  logic          sel_dir;

  int n_checks = 0;
  int n_errors = 0;

  cht_shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_amt   (cmd_amt),
    .cmd_fill  (cmd_fill),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .sel_hold  (sel_hold),
    .sel_dir   (sel_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Result of amt single-position shifts, expressed as one whole-word operation.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dr,
                                         input int amt, input logic f);
    logic [W-1:0] ones;
    int r;
    ones = '1;
`ifdef CHT_SEQ_ROTATE_EN
    r = amt % W;
    if (r == 0) return d;
    return dr ? ((d >> r) | (d << (W - r))) : ((d << r) | (d >> (W - r)));
`else
    r = amt;
    if (r >= W) return {W{f}};
    if (dr) return (d >> r) | (f ? ~(ones >> r) : '0);
    return (d << r) | (f ? ~(ones << r) : '0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] d, input logic dr, input int amt, input logic f);
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dr;
    cmd_amt   = CW'(amt);
    cmd_fill  = f;
    tick();
    // Scramble the command bus after accept; it must have no further effect.
    cmd_valid = 1'b0;
    cmd_data  = W'($urandom);
    cmd_dir   = 1'($urandom);
    cmd_amt   = CW'($urandom);
    cmd_fill  = 1'($urandom);
  endtask

  task automatic run_cmd(input logic [W-1:0] d, input logic dr, input int amt,
                         input logic f, input int hold);
    logic [W-1:0] exp;
    exp = model(d, dr, amt, f);
    accept(d, dr, amt, f);
    for (int i = 0; i < amt; i++) begin
      check("shift_sel_hold", {31'b0, sel_hold}, 32'd0);
      check("shift_res_valid", {31'b0, res_valid}, 32'd0);
      check("shift_sel_dir", {31'b0, sel_dir}, {31'b0, dr});
      tick();
    end
    check("done_res_valid", {31'b0, res_valid}, 32'd1);
    check("done_res_data", {16'b0, res_data}, {16'b0, exp});
    check("done_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("done_sel_hold", {31'b0, sel_hold}, 32'd1);
    check("done_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_res_valid", {31'b0, res_valid}, 32'd1);
      check("hold_res_data", {16'b0, res_data}, {16'b0, exp});
      check("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_res_valid", {31'b0, res_valid}, 32'd0);
    check("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_res_data", {16'b0, res_data}, {16'b0, exp});
    check("post_sel_dir", {31'b0, sel_dir}, {31'b0, dr});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_data"}, {16'b0, res_data}, 32'd0);
    check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_sel_hold"}, {31'b0, sel_hold}, 32'd1);
    check({tag, "_sel_dir"}, {31'b0, sel_dir}, 32'd0);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_amt   = '0;
    cmd_fill  = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Directed: 0x8001 left by 3, fill 0.
`ifdef CHT_SEQ_ROTATE_EN
    check("model_plan1", {16'b0, model(16'h8001, 1'b0, 3, 1'b0)}, 32'h000C);
    check("model_plan3", {16'b0, model(16'h1234, 1'b1, 20, 1'b1)}, 32'h4123);
`else
    check("model_plan1", {16'b0, model(16'h8001, 1'b0, 3, 1'b0)}, 32'h0008);
    check("model_plan3", {16'b0, model(16'h1234, 1'b1, 20, 1'b1)}, 32'hFFFF);
`endif
    run_cmd(16'h8001, 1'b0, 3, 1'b0, 0);
    // Zero-amount command with consumer stalling 5 cycles.
    run_cmd(16'hA5A5, 1'b1, 0, 1'b0, 5);
    // Amount beyond the data width.
    run_cmd(16'h1234, 1'b1, 20, 1'b1, 1);
    run_cmd(16'hBEEF, 1'b0, 31, 1'b0, 0);

    // Abort after 4 shift cycles of a 10-shift command.
    accept(16'hC3C3, 1'b0, 10, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("pre_abort_sel_hold", {31'b0, sel_hold}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_sel_hold", {31'b0, sel_hold}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("abort_no_result", {31'b0, res_valid}, 32'd0);
      tick();
    end
    run_cmd(16'h0F0F, 1'b1, 1, 1'b1, 0);

    // Abort while a result waits in DONE discards it.
    accept(16'h5555, 1'b0, 0, 1'b0);
    check("done_before_abort", {31'b0, res_valid}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_res_valid", {31'b0, res_valid}, 32'd0);
    check("abort_done_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Abort in IDLE blocks a simultaneous command.
    cmd_valid = 1'b1;
    cmd_amt   = CW'(0);
    abort     = 1'b1;
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check("idle_abort_no_accept", {31'b0, busy}, 32'd0);

    // Reset mid-SHIFT with cmd_valid and abort also high.
    accept(16'h7E81, 1'b1, 8, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_amt   = CW'(0);
    abort     = 1'b1;
    tick();
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check_reset_outputs("midreset");
    tick();
    check("after_reset_idle", {31'b0, busy}, 32'd0);

    // Randomized commands against the model.
    for (int n = 0; n < 40; n++) begin
      run_cmd(W'($urandom), 1'($urandom), int'($urandom_range(0, 31)),
              1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
